pla_sex_stim_sequencer: RTL

//  Upstream stage of pla__sex. Feeds the 9 PLA inputs x0..x8 from a valid/ready vector stream buffered in a FIFO.

---
 rtl/pla_sex_pkg.sv | 34 +++
 rtl/pla_sex_vec_fifo.sv | 89 ++++++++
 rtl/pla_sex_stim_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pla_sex_pkg.sv
// -----------------------------------------------------------------------------
// pla_sex_pkg
// Shared definitions for the pla__sex stimulus sequencer:
//   N_IN / N_OUT      PLA input and output widths
//   seq_state_t       sequencer FSM states
//   MISR_*_DEF        default MISR taps and seed
//   misr_step()       one MISR fold of a 14-bit PLA response
// -----------------------------------------------------------------------------
package pla_sex_pkg;

    localparam int N_IN  = 9;
    localparam int N_OUT = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam logic [N_OUT-1:0] MISR_POLY_DEF = 14'h0443;
    localparam logic [N_OUT-1:0] MISR_SEED_DEF = 14'h0001;

    // Shift left, apply the feedback taps when the MSB falls out, fold in z.
    function automatic logic [N_OUT-1:0] misr_step(
        input logic [N_OUT-1:0] sig,
        input logic [N_OUT-1:0] z,
        input logic [N_OUT-1:0] poly
    );
        logic [N_OUT-1:0] fb;
        fb = sig[N_OUT-1] ? poly : {N_OUT{1'b0}};
        return {sig[N_OUT-2:0], 1'b0} ^ fb ^ z;
    endfunction

endpackage

// File: rtl/pla_sex_vec_fifo.sv
// -----------------------------------------------------------------------------
// pla_sex_vec_fifo
// Synchronous FIFO_DEPTH x N_IN vector buffer with registered full/empty.
//   clk, rst     clock, asynchronous active-high reset (flushes the FIFO)
//   wr_en        push request, accepted only when not full
//   wr_data      vector to push
//   rd_en        pop request, honoured only when not empty
//   rd_data      head entry (valid while empty = 0)
//   full, empty  registered status flags
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
// -----------------------------------------------------------------------------
module pla_sex_vec_fifo
    import pla_sex_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [N_IN-1:0] wr_data,
    input  logic            rd_en,
    output logic [N_IN-1:0] rd_data,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [N_IN-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_r;
    logic [AW:0]     rd_ptr_r;
    logic [AW:0]     wr_ptr_s;
    logic [AW:0]     rd_ptr_s;
    logic            full_r;
    logic            empty_r;
    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            empty_s;

    // Handshake qualification and next-pointer / next-flag computation.
    always_comb begin
        push_s = wr_en & ~full_r;
        pop_s  = rd_en & ~empty_r;
        if (push_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        full_s  = (wr_ptr_s[AW] != rd_ptr_s[AW]) &&
                  (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]);
        empty_s = (wr_ptr_s == rd_ptr_s);
    end

    // Pointer and flag registers; full reads 1 during reset so nothing is
    // accepted until the first clock edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            full_r   <= 1'b1;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            full_r   <= full_s;
            empty_r  <= empty_s;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
    assign full    = full_r;
    assign empty   = empty_r;

endmodule

// File: rtl/pla_sex_stim_sequencer.sv
// -----------------------------------------------------------------------------
// pla_sex_stim_sequencer
// Drives the 9 pla__sex inputs either from a buffered valid/ready vector
// stream (IDLE) or from a self-test counter 0..SWEEP_LAST (SWEEP), folding the
// PLA response into a MISR signature during the sweep.
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  vector stream handshake (ready = FIFO not full)
//   in_vec          vector, in_vec[i] -> xi
//   start_sweep     pulse, honoured only in IDLE
//   x0..x8          registered PLA inputs
//   vec_valid       x0..x8 carry a new vector this cycle
//   z_in            PLA response, z_in[0] = z00
//   busy            sequencer not IDLE
//   sweep_done      one-cycle pulse after the last sweep vector
//   signature       MISR value, held after DONE until the next sweep
// -----------------------------------------------------------------------------
module pla_sex_stim_sequencer
    import pla_sex_pkg::*;
#(
    parameter int               FIFO_DEPTH = 4,
    parameter logic [N_IN-1:0]  SWEEP_LAST = 9'd511,
    parameter logic [N_OUT-1:0] MISR_POLY  = MISR_POLY_DEF,
    parameter logic [N_OUT-1:0] MISR_SEED  = MISR_SEED_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    input  logic             start_sweep,
    output logic             x0,
    output logic             x1,
    output logic             x2,
    output logic             x3,
    output logic             x4,
    output logic             x5,
    output logic             x6,
    output logic             x7,
    output logic             x8,
    output logic             vec_valid,
    input  logic [N_OUT-1:0] z_in,
    output logic             busy,
    output logic             sweep_done,
    output logic [N_OUT-1:0] signature
);

    seq_state_t       state_r;
    logic [N_IN-1:0]  cnt_r;
    logic [N_IN-1:0]  x_r;
    logic             vec_valid_r;
    logic             busy_r;
    logic             sweep_done_r;
    logic [N_OUT-1:0] sig_r;

    logic [N_IN-1:0]  fifo_data_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             pop_s;

    pla_sex_vec_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_vec),
        .rd_en   (pop_s),
        .rd_data (fifo_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Pop only in IDLE, and never on the edge that starts a sweep.
    always_comb begin
        if ((state_r == IDLE) && !start_sweep && !fifo_empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Sequencer FSM, sweep counter, registered PLA inputs and MISR.
    // In SWEEP x always equals cnt. The edge retiring the last vector moves
    // to DONE without folding, so a sweep of N vectors folds N-1 responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 9'd0;
            x_r          <= 9'd0;
            vec_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            sweep_done_r <= 1'b0;
            sig_r        <= 14'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    sweep_done_r <= 1'b0;
                    if (start_sweep) begin
                        state_r     <= SWEEP;
                        cnt_r       <= 9'd0;
                        x_r         <= 9'd0;
                        vec_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                        sig_r       <= MISR_SEED;
                    end else if (pop_s) begin
                        x_r         <= fifo_data_s;
                        vec_valid_r <= 1'b1;
                    end else begin
                        vec_valid_r <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (cnt_r == SWEEP_LAST) begin
                        state_r      <= DONE;
                        vec_valid_r  <= 1'b0;
                        sweep_done_r <= 1'b1;
                    end else begin
                        sig_r       <= misr_step(sig_r, z_in, MISR_POLY);
                        cnt_r       <= cnt_r + 9'd1;
                        x_r         <= cnt_r + 9'd1;
                        vec_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    vec_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    sweep_done_r <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    vec_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    sweep_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = ~fifo_full_s;
    assign x0         = x_r[0];
    assign x1         = x_r[1];
    assign x2         = x_r[2];
    assign x3         = x_r[3];
    assign x4         = x_r[4];
    assign x5         = x_r[5];
    assign x6         = x_r[6];
    assign x7         = x_r[7];
    assign x8         = x_r[8];
    assign vec_valid  = vec_valid_r;
    assign busy       = busy_r;
    assign sweep_done = sweep_done_r;
    assign signature  = sig_r;

endmodule
